dino_game_ctrl: RTL and testbench

Game-sequencing controller for the Chrome Dino design. It runs the IDLE/RUN/OVER state machine and qualifies the per-pixel `crash` level from the collision detector into a once-per-frame game-over decision, with a start-of-game grace period. It also keeps the BCD score, high score and speed level, and gates the scrolling and jump logic. It sits between the VGA frame timing, the collision detector and the obstacle/dino motion blocks.

---
 rtl/dino_pkg.sv | 32 +++
 rtl/bcd_counter4.sv | 51 +++++
 rtl/dino_game_ctrl.sv | 146 ++++++++++++++
 tb/tb_dino_game_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared types and helpers for the Dino game controller: state encoding,
// BCD score geometry and a digit-wise BCD magnitude compare.
package dino_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } game_state_e;

  localparam int BCD_W        = 4;
  localparam int SCORE_DIGITS = 4;
  localparam int SCORE_W      = BCD_W * SCORE_DIGITS;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;

  // True when a > b, comparing BCD digits from the most significant down.
  function automatic logic bcd_gt(input logic [SCORE_W-1:0] a,
                                  input logic [SCORE_W-1:0] b);
    logic gt;
    logic decided;
    gt      = 1'b0;
    decided = 1'b0;
    for (int i = SCORE_DIGITS - 1; i >= 0; i--) begin
      if (!decided && (a[i*BCD_W +: BCD_W] != b[i*BCD_W +: BCD_W])) begin
        gt      = (a[i*BCD_W +: BCD_W] > b[i*BCD_W +: BCD_W]);
        decided = 1'b1;
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear and saturation at 9999.
// hundreds_roll is a same-cycle strobe for increments that land on xx00.
module bcd_counter4
  import dino_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] value,
  output logic               hundreds_roll
);

  logic [SCORE_W-1:0] value_q, value_d;
  logic [SCORE_W-1:0] inc_val;
  logic               carry;
  logic               sat;

  always_comb begin
    inc_val = value_q;
    carry   = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (carry) begin
        if (value_q[i*BCD_W +: BCD_W] == BCD_W'(9)) begin
          inc_val[i*BCD_W +: BCD_W] = '0;
        end else begin
          inc_val[i*BCD_W +: BCD_W] = value_q[i*BCD_W +: BCD_W] + BCD_W'(1);
          carry = 1'b0;
        end
      end
    end

    sat           = (value_q == SCORE_MAX);
    value_d       = value_q;
    hundreds_roll = 1'b0;
    if (clr) begin
      value_d = '0;
    end else if (inc && !sat) begin
      value_d       = inc_val;
      hundreds_roll = (inc_val[2*BCD_W-1:0] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/dino_game_ctrl.sv
// Game sequencer: IDLE/RUN/OVER FSM, once-per-frame crash qualification with
// a start grace period, score/high-score/speed bookkeeping and jump gating.
module dino_game_ctrl
  import dino_pkg::*;
#(
  parameter int GRACE_FRAMES = 30,
  parameter int SCORE_DIV    = 6,
  parameter int MAX_SPEED    = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        rdn,
  input  logic        crash,
  input  logic        start_btn,
  input  logic        jump_btn,
  output logic [1:0]  state,
  output logic        run_en,
  output logic        jump_pulse,
  output logic        det_rst,
  output logic [15:0] score,
  output logic [15:0] hi_score,
  output logic [2:0]  speed
);

  localparam int GRACE_W = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;
  localparam int DIV_W   = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;

  game_state_e        state_q, state_d;
  logic               armed_q, start_q, jump_q;
  logic [GRACE_W-1:0] grace_q, grace_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               crash_seen_q, crash_seen_d;
  logic               run_en_q, run_en_d;
  logic               jump_pulse_q, jump_pulse_d;
  logic               det_rst_q, det_rst_d;
  logic [15:0]        hi_q, hi_d;
  logic [2:0]         speed_q, speed_d;

  logic               start_rise, jump_rise, crash_now;
  logic               score_clr, score_inc, hundreds_roll;
  logic [15:0]        score_w;

  bcd_counter4 u_score (
    .clk           (clk),
    .rst           (rst),
    .clr           (score_clr),
    .inc           (score_inc),
    .value         (score_w),
    .hundreds_roll (hundreds_roll)
  );

  always_comb begin
    // armed_q masks the first cycle after reset so a held button is not a rise.
    start_rise   = start_btn & ~start_q & armed_q;
    jump_rise    = jump_btn & ~jump_q & armed_q;
    crash_now    = ~rdn & crash;

    state_d      = state_q;
    grace_d      = grace_q;
    div_d        = div_q;
    crash_seen_d = crash_seen_q;
    hi_d         = hi_q;
    speed_d      = speed_q;
    score_clr    = 1'b0;
    score_inc    = 1'b0;
    jump_pulse_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          state_d      = ST_RUN;
          score_clr    = 1'b1;
          speed_d      = '0;
          grace_d      = GRACE_W'(GRACE_FRAMES);
          div_d        = '0;
          crash_seen_d = 1'b0;
        end
      end
      ST_RUN: begin
        jump_pulse_d = jump_rise;
        crash_seen_d = crash_seen_q | crash_now;
        if (frame_tick) begin
          crash_seen_d = 1'b0;
          if ((grace_q == '0) && (crash_seen_q | crash_now)) begin
            state_d = ST_OVER;
            if (bcd_gt(score_w, hi_q)) hi_d = score_w;
          end else begin
            if (grace_q != '0) grace_d = grace_q - 1'b1;
            if (div_q == DIV_W'(SCORE_DIV - 1)) begin
              div_d     = '0;
              score_inc = 1'b1;
            end else begin
              div_d = div_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (hundreds_roll && (speed_q != 3'(MAX_SPEED))) speed_d = speed_q + 3'd1;

    run_en_d  = (state_d == ST_RUN);
    det_rst_d = (state_d == ST_RUN) && (state_q != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      armed_q      <= 1'b0;
      start_q      <= 1'b0;
      jump_q       <= 1'b0;
      grace_q      <= '0;
      div_q        <= '0;
      crash_seen_q <= 1'b0;
      run_en_q     <= 1'b0;
      jump_pulse_q <= 1'b0;
      det_rst_q    <= 1'b0;
      hi_q         <= '0;
      speed_q      <= '0;
    end else begin
      state_q      <= state_d;
      armed_q      <= 1'b1;
      start_q      <= start_btn;
      jump_q       <= jump_btn;
      grace_q      <= grace_d;
      div_q        <= div_d;
      crash_seen_q <= crash_seen_d;
      run_en_q     <= run_en_d;
      jump_pulse_q <= jump_pulse_d;
      det_rst_q    <= det_rst_d;
      hi_q         <= hi_d;
      speed_q      <= speed_d;
    end
  end

  assign state      = state_q;
  assign run_en     = run_en_q;
  assign jump_pulse = jump_pulse_q;
  assign det_rst    = det_rst_q;
  assign score      = score_w;
  assign hi_score   = hi_q;
  assign speed      = speed_q;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Directed testbench for dino_game_ctrl: a default-parameter instance for the
// game flow and a SCORE_DIV=1 instance for score saturation.
module tb_dino_game_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick, rdn, crash, start_btn, jump_btn;
  logic [1:0]  state;
  logic        run_en, jump_pulse, det_rst;
  logic [15:0] score, hi_score;
  logic [2:0]  speed;

  logic        f_frame_tick, f_rdn, f_crash, f_start_btn, f_jump_btn;
  logic [1:0]  f_state;
  logic        f_run_en, f_jump_pulse, f_det_rst;
  logic [15:0] f_score, f_hi_score;
  logic [2:0]  f_speed;

  int checks = 0;
  int errors = 0;
  int det_cnt = 0;
  int jump_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (det_rst)    det_cnt  <= det_cnt + 1;
    if (jump_pulse) jump_cnt <= jump_cnt + 1;
  end

  dino_game_ctrl u_dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .rdn(rdn), .crash(crash),
    .start_btn(start_btn), .jump_btn(jump_btn), .state(state), .run_en(run_en),
    .jump_pulse(jump_pulse), .det_rst(det_rst), .score(score),
    .hi_score(hi_score), .speed(speed)
  );

  dino_game_ctrl #(.GRACE_FRAMES(30), .SCORE_DIV(1), .MAX_SPEED(7)) u_dut_fast (
    .clk(clk), .rst(rst), .frame_tick(f_frame_tick), .rdn(f_rdn), .crash(f_crash),
    .start_btn(f_start_btn), .jump_btn(f_jump_btn), .state(f_state),
    .run_en(f_run_en), .jump_pulse(f_jump_pulse), .det_rst(f_det_rst),
    .score(f_score), .hi_score(f_hi_score), .speed(f_speed)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(1);
  endtask

  task automatic press_start();
    start_btn = 1'b0;
    cyc(1);
    start_btn = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_btn = 1'b1; jump_btn = 1'b0; frame_tick = 1'b0;
    rdn = 1'b1; crash = 1'b0;
    f_start_btn = 1'b0; f_jump_btn = 1'b0; f_frame_tick = 1'b0;
    f_rdn = 1'b1; f_crash = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(5);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", state); end
    checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL reset_run_en got %b exp 0", run_en); end
    checks++; if (det_rst !== 1'b0) begin errors++; $display("FAIL reset_det_rst got %b exp 0", det_rst); end
    checks++; if (jump_pulse !== 1'b0) begin errors++; $display("FAIL reset_jump_pulse got %b exp 0", jump_pulse); end
    checks++; if (score !== 16'h0000) begin errors++; $display("FAIL reset_score got %h exp 0000", score); end
    checks++; if (hi_score !== 16'h0000) begin errors++; $display("FAIL reset_hi_score got %h exp 0000", hi_score); end
    checks++; if (speed !== 3'd0) begin errors++; $display("FAIL reset_speed got %0d exp 0", speed); end
    jump_btn = 1'b1;
    cyc(1);
    checks++; if (jump_pulse !== 1'b0) begin errors++; $display("FAIL idle_jump got %b exp 0", jump_pulse); end
    jump_btn = 1'b0;
  endtask

  task automatic test_start();
    start_btn = 1'b0;
    cyc(1);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL release_state got %b exp 00", state); end
    start_btn = 1'b1;
    cyc(1);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL start_state got %b exp 01", state); end
    checks++; if (det_rst !== 1'b1) begin errors++; $display("FAIL start_det_rst got %b exp 1", det_rst); end
    checks++; if (run_en !== 1'b1) begin errors++; $display("FAIL start_run_en got %b exp 1", run_en); end
    cyc(1);
    checks++; if (det_rst !== 1'b0) begin errors++; $display("FAIL det_rst_width got %b exp 0", det_rst); end
  endtask

  task automatic test_grace_crash();
    rdn = 1'b0; crash = 1'b1;
    repeat (30) tick();
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL grace_30_state got %b exp 01", state); end
    tick();
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL grace_31_state got %b exp 10", state); end
    checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL over_run_en got %b exp 0", run_en); end
    checks++; if (score !== 16'h0005) begin errors++; $display("FAIL grace_score got %h exp 0005", score); end
    checks++; if (hi_score !== 16'h0005) begin errors++; $display("FAIL grace_hi got %h exp 0005", hi_score); end
    checks++; if (det_cnt !== 1) begin errors++; $display("FAIL det_rst_count got %0d exp 1", det_cnt); end
    rdn = 1'b1;
  endtask

  task automatic test_rdn_high_crash();
    press_start();
    checks++; if (score !== 16'h0000) begin errors++; $display("FAIL restart_score got %h exp 0000", score); end
    crash = 1'b1;
    repeat (40) tick();
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL rdn_high_state got %b exp 01", state); end
    checks++; if (score !== 16'h0006) begin errors++; $display("FAIL rdn_high_score got %h exp 0006", score); end
    rdn = 1'b0;
    cyc(1);
    rdn = 1'b1; crash = 1'b0;
    cyc(1);
    tick();
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL sticky_crash_state got %b exp 10", state); end
    checks++; if (hi_score !== 16'h0006) begin errors++; $display("FAIL sticky_hi got %h exp 0006", hi_score); end
  endtask

  task automatic test_score_speed();
    press_start();
    repeat (600) tick();
    checks++; if (score !== 16'h0100) begin errors++; $display("FAIL score600 got %h exp 0100", score); end
    checks++; if (speed !== 3'd1) begin errors++; $display("FAIL speed600 got %0d exp 1", speed); end
    rdn = 1'b0; crash = 1'b1;
    tick();
    rdn = 1'b1; crash = 1'b0;
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL score_over_state got %b exp 10", state); end
    checks++; if (hi_score !== 16'h0100) begin errors++; $display("FAIL hi_0100 got %h exp 0100", hi_score); end
    checks++; if (speed !== 3'd1) begin errors++; $display("FAIL over_speed_hold got %0d exp 1", speed); end
  endtask

  task automatic test_start_tick_over();
    int j0;
    start_btn = 1'b0;
    cyc(1);
    start_btn = 1'b1; frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL start_tick_state got %b exp 01", state); end
    checks++; if (score !== 16'h0000) begin errors++; $display("FAIL start_tick_score got %h exp 0000", score); end
    checks++; if (speed !== 3'd0) begin errors++; $display("FAIL start_tick_speed got %0d exp 0", speed); end
    checks++; if (det_rst !== 1'b1) begin errors++; $display("FAIL start_tick_det_rst got %b exp 1", det_rst); end
    rdn = 1'b0; crash = 1'b1;
    tick();
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL grace_reload_state got %b exp 01", state); end
    j0 = jump_cnt;
    jump_btn = 1'b1;
    cyc(1);
    checks++; if (jump_pulse !== 1'b1) begin errors++; $display("FAIL jump_pulse got %b exp 1", jump_pulse); end
    cyc(3);
    checks++; if (jump_pulse !== 1'b0) begin errors++; $display("FAIL jump_held got %b exp 0", jump_pulse); end
    checks++; if (jump_cnt - j0 !== 1) begin errors++; $display("FAIL jump_count got %0d exp 1", jump_cnt - j0); end
    jump_btn = 1'b0;
  endtask

  task automatic test_jump_on_over();
    repeat (29) tick();
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL pre_over_state got %b exp 01", state); end
    jump_btn = 1'b1; frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    checks++; if (jump_pulse !== 1'b1) begin errors++; $display("FAIL jump_at_over got %b exp 1", jump_pulse); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL jump_over_state got %b exp 10", state); end
    checks++; if (score !== 16'h0005) begin errors++; $display("FAIL low_score got %h exp 0005", score); end
    checks++; if (hi_score !== 16'h0100) begin errors++; $display("FAIL hi_keep got %h exp 0100", hi_score); end
    rdn = 1'b1; crash = 1'b0; jump_btn = 1'b0;
    cyc(1);
    jump_btn = 1'b1;
    cyc(1);
    checks++; if (jump_pulse !== 1'b0) begin errors++; $display("FAIL over_jump got %b exp 0", jump_pulse); end
    jump_btn = 1'b0;
  endtask

  task automatic test_mid_run_reset();
    press_start();
    repeat (12) tick();
    checks++; if (score !== 16'h0002) begin errors++; $display("FAIL pre_rst_score got %h exp 0002", score); end
    rst = 1'b1;
    cyc(1);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL mid_rst_state got %b exp 00", state); end
    checks++; if (hi_score !== 16'h0000) begin errors++; $display("FAIL mid_rst_hi got %h exp 0000", hi_score); end
    checks++; if (score !== 16'h0000) begin errors++; $display("FAIL mid_rst_score got %h exp 0000", score); end
    rst = 1'b0; start_btn = 1'b0;
    cyc(2);
  endtask

  task automatic test_saturation();
    f_start_btn = 1'b1;
    cyc(1);
    checks++; if (f_state !== 2'b01) begin errors++; $display("FAIL fast_start got %b exp 01", f_state); end
    checks++; if (f_det_rst !== 1'b1) begin errors++; $display("FAIL fast_det_rst got %b exp 1", f_det_rst); end
    f_frame_tick = 1'b1;
    cyc(300);
    checks++; if (f_score !== 16'h0300) begin errors++; $display("FAIL fast_score300 got %h exp 0300", f_score); end
    checks++; if (f_speed !== 3'd3) begin errors++; $display("FAIL fast_speed300 got %0d exp 3", f_speed); end
    cyc(9698);
    checks++; if (f_score !== 16'h9998) begin errors++; $display("FAIL fast_score9998 got %h exp 9998", f_score); end
    checks++; if (f_speed !== 3'd7) begin errors++; $display("FAIL fast_speed_sat got %0d exp 7", f_speed); end
    cyc(5);
    f_frame_tick = 1'b0;
    checks++; if (f_score !== 16'h9999) begin errors++; $display("FAIL fast_score_sat got %h exp 9999", f_score); end
    checks++; if (f_speed !== 3'd7) begin errors++; $display("FAIL fast_speed_end got %0d exp 7", f_speed); end
    checks++; if (f_run_en !== 1'b1) begin errors++; $display("FAIL fast_run_en got %b exp 1", f_run_en); end
    checks++; if (f_hi_score !== 16'h0000) begin errors++; $display("FAIL fast_hi got %h exp 0000", f_hi_score); end
    checks++; if (f_jump_pulse !== 1'b0) begin errors++; $display("FAIL fast_jump got %b exp 0", f_jump_pulse); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_grace_crash();
    test_rdn_high_crash();
    test_score_speed();
    test_start_tick_over();
    test_jump_on_over();
    test_mid_run_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
